// File: rtl/mac_pkg.sv
// Shared definitions for the dual-dataflow MAC row: instruction bit positions, mode encodings, helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mac_pkg;

    // Bit positions inside the 3-bit instruction word.
    localparam int INST_LOAD  = 0;
    localparam int INST_EXEC  = 1;
    localparam int INST_DRAIN = 2;
    localparam int INST_W     = 3;

    // Dataflow mode carried alongside each instruction.
    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    // Signed product of two operands that the caller has already sign-extended
    // to 32 bits. The caller truncates the result to its accumulator width, which
    // gives the sign-extended bw x bw product taken modulo 2^psum_bw.
    function automatic logic signed [63:0] sext_prod(input logic signed [31:0] a,
                                                     input logic signed [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Priority decode: drain > execute > load. The result is one-hot or zero,
    // so lower bits set together with a higher bit are ignored.
    function automatic logic [INST_W-1:0] inst_decode(input logic [INST_W-1:0] inst);
        logic [INST_W-1:0] dec;
        dec = '0;
        if (inst[INST_DRAIN]) begin
            dec[INST_DRAIN] = 1'b1;
        end else if (inst[INST_EXEC]) begin
            dec[INST_EXEC] = 1'b1;
        end else if (inst[INST_LOAD]) begin
            dec[INST_LOAD] = 1'b1;
        end
        return dec;
    endfunction

endpackage

// File: rtl/mac_tile_dual.sv
// One MAC tile supporting weight-stationary and output-stationary dataflow plus drain.
// Latency: 1 cycle from in_w/inst_w/mode_w/in_n to out_s/valid and to out_e/inst_e/mode_e.
// Backpressure: none; the tile accepts one instruction per cycle and never stalls.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_w / out_e        activation from the west tile / registered copy to the east tile
//   inst_w / inst_e     raw instruction from the west / decoded instruction to the east
//   mode_w / mode_e     dataflow mode from the west / registered copy to the east
//   in_n / out_s        psum (WS) or weight in [bw-1:0] (OS) from north / result south
//   valid               high the cycle out_s carries a result
module mac_tile_dual
    import mac_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [bw-1:0]        in_w,
    output logic [bw-1:0]        out_e,
    input  logic [INST_W-1:0]    inst_w,
    output logic [INST_W-1:0]    inst_e,
    input  logic                 mode_w,
    output logic                 mode_e,
    input  logic [psum_bw-1:0]   in_n,
    output logic [psum_bw-1:0]   out_s,
    output logic                 valid
);

    logic [bw-1:0]          a_q;
    logic signed [bw-1:0]   b_q;
    logic [psum_bw-1:0]     acc_q;
    logic [INST_W-1:0]      inst_q;
    logic                   mode_q;
    logic                   load_ready_q;
    logic [psum_bw-1:0]     out_s_q;
    logic                   valid_q;

    logic [INST_W-1:0]      inst_dec;
    logic                   capture;
    logic signed [bw-1:0]   a_in;
    logic signed [bw-1:0]   w_os;
    logic [psum_bw-1:0]     w_os_ext;
    logic [psum_bw-1:0]     prod_ws;
    logic [psum_bw-1:0]     prod_os;

    // The arithmetic works on the activation arriving this cycle (the value a_q
    // takes at this edge), so the result appears one cycle after the inputs.
    always_comb begin
        inst_dec = inst_decode(inst_w);
        capture  = inst_dec[INST_LOAD] && (mode_w == MODE_WS) && load_ready_q;
        a_in     = in_w;
        w_os     = in_n[bw-1:0];
        w_os_ext = psum_bw'(w_os);
        prod_ws  = psum_bw'(sext_prod(32'(a_in), 32'(b_q)));
        prod_os  = psum_bw'(sext_prod(32'(a_in), 32'(w_os)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            inst_q       <= '0;
            mode_q       <= MODE_WS;
            load_ready_q <= 1'b1;
            out_s_q      <= '0;
            valid_q      <= 1'b0;
        end else begin
            // A tile that captures a weight swallows that load so the next
            // weight in the stream lands in the next tile east.
            inst_q  <= capture ? '0 : inst_dec;
            mode_q  <= mode_w;
            valid_q <= 1'b0;

            if (inst_dec != '0) begin
                a_q <= in_w;
            end

            if (capture) begin
                b_q          <= in_w;
                load_ready_q <= 1'b0;
            end

            if (inst_dec[INST_DRAIN]) begin
                out_s_q      <= acc_q;
                valid_q      <= 1'b1;
                acc_q        <= '0;
                load_ready_q <= 1'b1;
            end else if (inst_dec[INST_EXEC]) begin
                if (mode_w == MODE_OS) begin
                    // Weight continues south; the sum stays local until drained.
                    acc_q   <= acc_q + prod_os;
                    out_s_q <= w_os_ext;
                end else begin
                    out_s_q <= in_n + prod_ws;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign out_e  = a_q;
    assign inst_e = inst_q;
    assign mode_e = mode_q;
    assign out_s  = out_s_q;
    assign valid  = valid_q;

endmodule

// File: rtl/mac_row_dual.sv
// One systolic-array row: col dual-dataflow MAC tiles chained west to east.
// Latency: tile i produces out_s/valid i+1 cycles after an instruction enters at the west edge.
// Backpressure: none; one instruction per cycle is accepted unconditionally.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   in_w         west activation (kernel data during WS load)
//   inst_w       [0] load, [1] execute, [2] drain
//   mode         0 = WS, 1 = OS; travels east with each instruction
//   in_n         per column psum in (WS) or weight in [bw-1:0] (OS)
//   out_s        per column psum out (WS), weight pass-down or drained accumulator (OS)
//   valid        per column result strobe
module mac_row_dual
    import mac_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [bw-1:0]            in_w,
    input  logic [INST_W-1:0]        inst_w,
    input  logic                     mode,
    input  logic [psum_bw*col-1:0]   in_n,
    output logic [psum_bw*col-1:0]   out_s,
    output logic [col-1:0]           valid
);

    // Entry 0 is the row input; entry col is the east edge, which has no consumer.
    logic [bw-1:0]     a_chain    [col+1];
    logic [INST_W-1:0] inst_chain [col+1];
    logic              mode_chain [col+1];

    assign a_chain[0]    = in_w;
    assign inst_chain[0] = inst_w;
    assign mode_chain[0] = mode;

    for (genvar i = 0; i < col; i++) begin : g_tile
        mac_tile_dual #(
            .bw      (bw),
            .psum_bw (psum_bw)
        ) u_tile (
            .clk    (clk),
            .reset  (reset),
            .in_w   (a_chain[i]),
            .out_e  (a_chain[i+1]),
            .inst_w (inst_chain[i]),
            .inst_e (inst_chain[i+1]),
            .mode_w (mode_chain[i]),
            .mode_e (mode_chain[i+1]),
            .in_n   (in_n[i*psum_bw +: psum_bw]),
            .out_s  (out_s[i*psum_bw +: psum_bw]),
            .valid  (valid[i])
        );
    end

endmodule
